card_state_rf: RTL and testbench

Parametrised card-state register file for the memory game, holding one entry per card: state bits [1:0] plus an RGB colour field above them. It keeps the generic single-write/async-read access used by the display and game logic. It adds an automatic clear sweep after reset or on request, and a hardware pair-compare engine that resolves two face-up cards in place. It sits between the game controller (writes, compare requests) and the card renderer (reads).

---
 rtl/card_pkg.sv | 25 ++
 rtl/card_rf_mem.sv | 33 +++
 rtl/card_state_rf.sv | 190 +++++++++++++++++++
 tb/tb_card_state_rf.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types and constants for the card-state register file: card state
// encodings, controller FSM states and the default colour width.
package card_pkg;

    localparam int CARD_COLOR_W = 12;

    typedef enum logic [1:0] {
        CARD_INACTIVE  = 2'b00,
        CARD_FACE_UP   = 2'b01,
        CARD_FACE_DOWN = 2'b10
    } card_state_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMP,
        ST_WB_B
    } fsm_state_e;

    // State written back to both cards once a legal compare resolves.
    function automatic logic [1:0] resolved_state(input logic colour_match);
        return colour_match ? CARD_INACTIVE : CARD_FACE_DOWN;
    endfunction

endpackage

// File: rtl/card_rf_mem.sv
// Card entry storage: one synchronous write port and three asynchronous read
// ports (renderer read plus the two compare operands).
module card_rf_mem #(
    parameter int CARDS = 16,
    parameter int DATA_W = 14,
    localparam int ADDR_W = $clog2(CARDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_rdata,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    // No reset: the parent's clear sweep initialises every entry.
    logic [DATA_W-1:0] mem_q [CARDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign r_rdata = mem_q[r_addr];
    assign a_rdata = mem_q[a_addr];
    assign b_rdata = mem_q[b_addr];

endmodule

// File: rtl/card_state_rf.sv
// Card-state register file with clear sweep and in-place pair-compare engine.
// Optional pair counter enabled by defining CARD_STATE_RF_PAIRCNT_EN.
module card_state_rf
    import card_pkg::*;
#(
    parameter int CARDS = 16,
    parameter int COLOR_W = CARD_COLOR_W,
    localparam int DATA_W = COLOR_W + 2,
    localparam int ADDR_W = $clog2(CARDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_enable,
    input  logic [ADDR_W-1:0] w_address,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_address,
    output logic [DATA_W-1:0] r_data,
    input  logic              init_req,
    input  logic              cmp_req,
    input  logic [ADDR_W-1:0] cmp_a,
    input  logic [ADDR_W-1:0] cmp_b,
    output logic              busy,
    output logic              cmp_done,
    output logic              cmp_match,
    output logic              cmp_err,
    output logic [ADDR_W-1:0] pairs_left,
    output logic              all_cleared
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(CARDS - 1);

    fsm_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic              busy_q;
    logic              done_q;
    logic              match_q;
    logic              err_q;
    logic              pend_match_q;
    logic              pend_err_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              cmp_legal;
    logic              cmp_colour_eq;

    card_rf_mem #(
        .CARDS  (CARDS),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .r_addr  (r_address),
        .r_rdata (r_data),
        .a_addr  (a_q),
        .a_rdata (a_data),
        .b_addr  (b_q),
        .b_rdata (b_data)
    );

    // Reserved state 11 is deliberately not face up, so it makes a request illegal.
    assign cmp_legal     = (a_q != b_q) && (a_data[1:0] == CARD_FACE_UP)
                                        && (b_data[1:0] == CARD_FACE_UP);
    assign cmp_colour_eq = (a_data[DATA_W-1:2] == b_data[DATA_W-1:2]);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_address;
        mem_wdata = w_data;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
            end
            ST_IDLE: begin
                mem_we = w_enable;
            end
            ST_CMP: begin
                mem_we    = cmp_legal;
                mem_waddr = a_q;
                mem_wdata = {a_data[DATA_W-1:2], resolved_state(cmp_colour_eq)};
            end
            ST_WB_B: begin
                mem_we    = !pend_err_q;
                mem_waddr = b_q;
                mem_wdata = {b_data[DATA_W-1:2], resolved_state(pend_match_q)};
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            err_q        <= 1'b0;
            pend_match_q <= 1'b0;
            pend_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_INIT;
                    end else if (cmp_req) begin
                        a_q     <= cmp_a;
                        b_q     <= cmp_b;
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    pend_err_q   <= !cmp_legal;
                    pend_match_q <= cmp_legal && cmp_colour_eq;
                    state_q      <= ST_WB_B;
                end
                ST_WB_B: begin
                    done_q  <= 1'b1;
                    match_q <= pend_match_q;
                    err_q   <= pend_err_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign cmp_done  = done_q;
    assign cmp_match = match_q;
    assign cmp_err   = err_q;

`ifdef CARD_STATE_RF_PAIRCNT_EN
    logic [ADDR_W-1:0] pairs_left_q;
    logic [ADDR_W-1:0] pairs_left_d;

    always_comb begin
        pairs_left_d = pairs_left_q;
        if (state_q == ST_INIT && idx_q == IDX_LAST) begin
            pairs_left_d = ADDR_W'(CARDS / 2);
        end else if (state_q == ST_WB_B && pend_match_q && pairs_left_q != '0) begin
            pairs_left_d = pairs_left_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pairs_left_q <= '0;
        end else begin
            pairs_left_q <= pairs_left_d;
        end
    end

    assign pairs_left  = pairs_left_q;
    assign all_cleared = (pairs_left_q == '0) && !busy_q;
`else
    assign pairs_left  = '0;
    assign all_cleared = 1'b0;
`endif

endmodule

// File: tb/tb_card_state_rf.sv
// Self-checking bench for card_state_rf: directed scenarios plus a randomised
// back-to-back run against an array-based reference of the card table.
module tb_card_state_rf;

    localparam int CARDS   = 16;
    localparam int COLOR_W = 12;
    localparam int DATA_W  = COLOR_W + 2;
    localparam int ADDR_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              w_enable;
    logic [ADDR_W-1:0] w_address;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic              init_req;
    logic              cmp_req;
    logic [ADDR_W-1:0] cmp_a;
    logic [ADDR_W-1:0] cmp_b;
    logic              busy;
    logic              cmp_done;
    logic              cmp_match;
    logic              cmp_err;
    logic [ADDR_W-1:0] pairs_left;
    logic              all_cleared;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mdl [CARDS];
    int                mdl_pairs = 0;

    card_state_rf #(.CARDS(CARDS), .COLOR_W(COLOR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_enable    (w_enable),
        .w_address   (w_address),
        .w_data      (w_data),
        .r_address   (r_address),
        .r_data      (r_data),
        .init_req    (init_req),
        .cmp_req     (cmp_req),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .busy        (busy),
        .cmp_done    (cmp_done),
        .cmp_match   (cmp_match),
        .cmp_err     (cmp_err),
        .pairs_left  (pairs_left),
        .all_cleared (all_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic logic [ADDR_W-1:0] exp_pairs();
`ifdef CARD_STATE_RF_PAIRCNT_EN
        return ADDR_W'(mdl_pairs);
`else
        return '0;
`endif
    endfunction

    function automatic logic exp_cleared_idle();
`ifdef CARD_STATE_RF_PAIRCNT_EN
        return (mdl_pairs == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_sweep();
        for (int i = 0; i < CARDS; i++) mdl[i] = '0;
        mdl_pairs = CARDS / 2;
    endtask

    // Reference: a pair resolves only if distinct and both face up.
    task automatic m_cmp(input int a, input int b, output logic em, output logic ee);
        logic [1:0] st;
        ee = (a == b) || (mdl[a][1:0] != 2'b01) || (mdl[b][1:0] != 2'b01);
        em = 1'b0;
        if (!ee) begin
            em = (mdl[a][DATA_W-1:2] == mdl[b][DATA_W-1:2]);
            st = em ? 2'b00 : 2'b10;
            mdl[a] = {mdl[a][DATA_W-1:2], st};
            mdl[b] = {mdl[b][DATA_W-1:2], st};
            if (em && mdl_pairs > 0) mdl_pairs--;
        end
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        w_address = ADDR_W'(a);
        w_data    = d;
        w_enable  = 1'b1;
        step();
        w_enable  = 1'b0;
        mdl[a]    = d;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input int a, output logic [DATA_W-1:0] d);
        r_address = ADDR_W'(a);
        #1;
        d = r_data;
    endtask

    // Issues a compare and stops in the cmp_done cycle so the next call is back-to-back.
    task automatic run_cmp(input int a, input int b, output logic o_busy,
                           output logic o_early, output logic o_done,
                           output logic o_match, output logic o_err);
        cmp_a   = ADDR_W'(a);
        cmp_b   = ADDR_W'(b);
        cmp_req = 1'b1;
        step();
        cmp_req = 1'b0;
        o_busy  = busy;
        step();
        o_early = cmp_done;
        step();
        o_done  = cmp_done;
        o_match = cmp_match;
        o_err   = cmp_err;
        $display("compare a=%0d b=%0d done=%b match=%b err=%b", a, b, o_done, o_match, o_err);
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        rst_n = 1'b0;
        #12;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if ({cmp_done, cmp_match, cmp_err, all_cleared} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {cmp_done, cmp_match, cmp_err, all_cleared}); end
        total++; if (pairs_left !== 4'd0) begin bad++; $display("FAIL reset_pairs: got %0d want 0", pairs_left); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= CARDS; k++) begin
            step();
            total++; if (busy !== (k < CARDS)) begin
                bad++; $display("FAIL reset_sweep_busy: edge %0d got %b want %b", k, busy, k < CARDS); end
        end
        m_sweep();
        for (int i = 0; i < CARDS; i++) begin
            rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL reset_entry: idx %0d got %h want %h", i, d, mdl[i]); end
        end
        total++; if (pairs_left !== exp_pairs()) begin bad++; $display("FAIL reset_pairs_after: got %0d want %0d", pairs_left, exp_pairs()); end
        total++; if (all_cleared !== exp_cleared_idle()) begin bad++; $display("FAIL reset_cleared: got %b want %b", all_cleared, exp_cleared_idle()); end
    endtask

    task automatic test_match();
        logic ob, oe, od, om, oerr, em, ee;
        logic [DATA_W-1:0] d;
        wr(3, {12'hF00, 2'b01});
        wr(7, {12'hF00, 2'b01});
        m_cmp(3, 7, em, ee);
        run_cmp(3, 7, ob, oe, od, om, oerr);
        total++; if (ob !== 1'b1) begin bad++; $display("FAIL match_busy_n: got %b want 1", ob); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL match_done_early: got %b want 0", oe); end
        total++; if (od !== 1'b1) begin bad++; $display("FAIL match_done: got %b want 1", od); end
        total++; if (om !== em || oerr !== ee) begin bad++; $display("FAIL match_result: got m=%b e=%b want m=%b e=%b", om, oerr, em, ee); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL match_busy_done: got %b want 0", busy); end
        step();
        total++; if (cmp_done !== 1'b0) begin bad++; $display("FAIL match_done_clear: got %b want 0", cmp_done); end
        total++; if (cmp_match !== em) begin bad++; $display("FAIL match_hold: got %b want %b", cmp_match, em); end
        rd(3, d);
        total++; if (d !== mdl[3]) begin bad++; $display("FAIL match_entry_a: got %h want %h", d, mdl[3]); end
        rd(7, d);
        total++; if (d !== mdl[7]) begin bad++; $display("FAIL match_entry_b: got %h want %h", d, mdl[7]); end
        total++; if (pairs_left !== exp_pairs()) begin bad++; $display("FAIL match_pairs: got %0d want %0d", pairs_left, exp_pairs()); end
    endtask

    task automatic test_mismatch();
        logic ob, oe, od, om, oerr, em, ee;
        logic [DATA_W-1:0] d;
        wr(3, {12'hF00, 2'b01});
        wr(7, {12'h0F0, 2'b01});
        m_cmp(3, 7, em, ee);
        run_cmp(3, 7, ob, oe, od, om, oerr);
        total++; if (od !== 1'b1 || om !== em || oerr !== ee) begin
            bad++; $display("FAIL mismatch_result: got d=%b m=%b e=%b want d=1 m=%b e=%b", od, om, oerr, em, ee); end
        step();
        rd(3, d);
        total++; if (d !== mdl[3]) begin bad++; $display("FAIL mismatch_entry_a: got %h want %h", d, mdl[3]); end
        rd(7, d);
        total++; if (d !== mdl[7]) begin bad++; $display("FAIL mismatch_entry_b: got %h want %h", d, mdl[7]); end
    endtask

    task automatic test_illegal();
        logic ob, oe, od, om, oerr, em, ee;
        logic [DATA_W-1:0] d;
        wr(5, {12'h123, 2'b01});
        m_cmp(5, 5, em, ee);
        run_cmp(5, 5, ob, oe, od, om, oerr);
        total++; if (od !== 1'b1 || om !== em || oerr !== ee) begin
            bad++; $display("FAIL illegal_same: got d=%b m=%b e=%b want d=1 m=%b e=%b", od, om, oerr, em, ee); end
        step();
        wr(6, {12'hABC, 2'b01});
        wr(2, {12'hABC, 2'b10});
        m_cmp(6, 2, em, ee);
        run_cmp(6, 2, ob, oe, od, om, oerr);
        total++; if (od !== 1'b1 || om !== em || oerr !== ee) begin
            bad++; $display("FAIL illegal_facedown: got d=%b m=%b e=%b want d=1 m=%b e=%b", od, om, oerr, em, ee); end
        step();
        for (int i = 0; i < CARDS; i++) begin
            rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL illegal_entry: idx %0d got %h want %h", i, d, mdl[i]); end
        end
    endtask

    task automatic test_same_cycle();
        logic ob, oe, od, om, oerr, em, ee;
        wr(8, {12'h5A5, 2'b01});
        mdl[9] = {12'h5A5, 2'b01};
        m_cmp(8, 9, em, ee);
        w_address = 4'd9;
        w_data    = {12'h5A5, 2'b01};
        w_enable  = 1'b1;
        run_cmp(8, 9, ob, oe, od, om, oerr);
        w_enable  = 1'b0;
        total++; if (od !== 1'b1 || om !== em || oerr !== ee) begin
            bad++; $display("FAIL same_cycle: got d=%b m=%b e=%b want d=1 m=%b e=%b", od, om, oerr, em, ee); end
        step();
    endtask

    task automatic test_busy_ignored();
        logic em, ee;
        logic [DATA_W-1:0] d;
        wr(10, {12'h111, 2'b01});
        wr(11, {12'h222, 2'b01});
        wr(0,  {12'h333, 2'b10});
        m_cmp(10, 11, em, ee);
        cmp_a = 4'd10; cmp_b = 4'd11; cmp_req = 1'b1;
        step();
        w_address = 4'd0; w_data = {12'hFFF, 2'b01}; w_enable = 1'b1;
        init_req = 1'b1; cmp_a = 4'd0; cmp_b = 4'd0;
        step();
        step();
        total++; if (cmp_done !== 1'b1 || cmp_match !== em || cmp_err !== ee) begin
            bad++; $display("FAIL busy_cmp: got d=%b m=%b e=%b want d=1 m=%b e=%b", cmp_done, cmp_match, cmp_err, em, ee); end
        w_enable = 1'b0; init_req = 1'b0; cmp_req = 1'b0;
        step();
        total++; if (busy !== 1'b0 || cmp_done !== 1'b0) begin
            bad++; $display("FAIL busy_dropped: got busy=%b done=%b want 0 0", busy, cmp_done); end
        for (int i = 0; i < CARDS; i++) begin
            rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL busy_entry: idx %0d got %h want %h", i, d, mdl[i]); end
        end
        // Reset in the cycle after entry a has been written.
        wr(12, {12'h444, 2'b01});
        wr(13, {12'h444, 2'b01});
        cmp_a = 4'd12; cmp_b = 4'd13; cmp_req = 1'b1;
        step();
        cmp_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || cmp_done !== 1'b0) begin
            bad++; $display("FAIL abort_reset: got busy=%b done=%b want 1 0", busy, cmp_done); end
        total++; if (pairs_left !== 4'd0) begin bad++; $display("FAIL abort_pairs: got %0d want 0", pairs_left); end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= CARDS; k++) begin
            step();
            total++; if (busy !== (k < CARDS) || cmp_done !== 1'b0) begin
                bad++; $display("FAIL abort_sweep: edge %0d got busy=%b done=%b want %b 0", k, busy, cmp_done, k < CARDS); end
        end
        m_sweep();
        for (int i = 0; i < CARDS; i++) begin
            rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL abort_entry: idx %0d got %h want %h", i, d, mdl[i]); end
        end
        total++; if (pairs_left !== exp_pairs()) begin bad++; $display("FAIL abort_pairs_after: got %0d want %0d", pairs_left, exp_pairs()); end
    endtask

    task automatic test_back_to_back();
        logic ob, oe, od, om, oerr, em, ee;
        logic [DATA_W-1:0] d;
        logic [1:0] st;
        int a, b;
        for (int i = 0; i < CARDS; i++) begin
            st = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
            wr(i, {12'($urandom_range(0, 3)), st});
        end
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                st = ($urandom_range(0, 4) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
                wr($urandom_range(0, CARDS - 1), {12'($urandom_range(0, 3)), st});
            end else begin
                a = $urandom_range(0, CARDS - 1);
                b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, CARDS - 1);
                m_cmp(a, b, em, ee);
                run_cmp(a, b, ob, oe, od, om, oerr);
                total++; if (ob !== 1'b1 || oe !== 1'b0 || od !== 1'b1) begin
                    bad++; $display("FAIL b2b_timing: it %0d got busy=%b early=%b done=%b want 1 0 1", it, ob, oe, od); end
                total++; if (om !== em || oerr !== ee) begin
                    bad++; $display("FAIL b2b_result: it %0d a=%0d b=%0d got m=%b e=%b want m=%b e=%b", it, a, b, om, oerr, em, ee); end
            end
        end
        step();
        for (int i = 0; i < CARDS; i++) begin
            rd(i, d);
            total++; if (d !== mdl[i]) begin bad++; $display("FAIL b2b_entry: idx %0d got %h want %h", i, d, mdl[i]); end
        end
        total++; if (pairs_left !== exp_pairs()) begin bad++; $display("FAIL b2b_pairs: got %0d want %0d", pairs_left, exp_pairs()); end
    endtask

    task automatic test_all_cleared();
        logic ob, oe, od, om, oerr, em, ee;
        for (int pass = 0; pass < 2; pass++) begin
            init_req = 1'b1;
            step();
            init_req = 1'b0;
            for (int k = 1; k <= CARDS; k++) begin
                step();
                total++; if (busy !== (k < CARDS) || (k < CARDS && all_cleared !== 1'b0)) begin
                    bad++; $display("FAIL clr_sweep: pass %0d edge %0d got busy=%b cleared=%b", pass, k, busy, all_cleared); end
            end
            m_sweep();
            total++; if (pairs_left !== exp_pairs() || all_cleared !== exp_cleared_idle()) begin
                bad++; $display("FAIL clr_reload: got pairs=%0d cleared=%b want %0d %b", pairs_left, all_cleared, exp_pairs(), exp_cleared_idle()); end
            if (pass == 0) begin
                for (int p = 0; p < CARDS / 2; p++) begin
                    wr(2 * p,     {12'(p + 1), 2'b01});
                    wr(2 * p + 1, {12'(p + 1), 2'b01});
                end
                for (int p = 0; p < CARDS / 2; p++) begin
                    m_cmp(2 * p, 2 * p + 1, em, ee);
                    run_cmp(2 * p, 2 * p + 1, ob, oe, od, om, oerr);
                    total++; if (od !== 1'b1 || om !== em || oerr !== ee) begin
                        bad++; $display("FAIL clr_pair: pair %0d got d=%b m=%b e=%b want d=1 m=%b e=%b", p, od, om, oerr, em, ee); end
                end
                total++; if (all_cleared !== exp_cleared_idle() || pairs_left !== exp_pairs()) begin
                    bad++; $display("FAIL clr_final: got cleared=%b pairs=%0d want %b %0d", all_cleared, pairs_left, exp_cleared_idle(), exp_pairs()); end
                step();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; w_enable = 1'b0; w_address = '0; w_data = '0; r_address = '0;
        init_req = 1'b0; cmp_req = 1'b0; cmp_a = '0; cmp_b = '0;
        test_reset();
        test_match();
        test_mismatch();
        test_illegal();
        test_same_cycle();
        test_busy_ignored();
        test_back_to_back();
        test_all_cleared();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
